intersection_controller: RTL and testbench



---
 rtl/intersection_controller.sv | 118 +++++++++++
 tb/tb_intersection_controller.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/intersection_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | intersection_controller: NS/EW traffic sequencer with exclusive WALK.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module intersection_controller #(
  parameter int unsigned GREEN_TIME  = 10,
  parameter int unsigned YELLOW_TIME = 5,
  parameter int unsigned ALLRED_TIME = 2,
  parameter int unsigned WALK_TIME   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ew_req,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_wait,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    NS_G    = 3'd0,
    NS_Y    = 3'd1,
    AR_A    = 3'd2,
    EW_G    = 3'd3,
    EW_Y    = 3'd4,
    AR_B    = 3'd5,
    WALK    = 3'd6,
    PED_CLR = 3'd7
  } state_t;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  localparam logic [7:0] GREEN_LAST  = 8'(GREEN_TIME - 1);
  localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_TIME - 1);
  localparam logic [7:0] ALLRED_LAST = 8'(ALLRED_TIME - 1);
  localparam logic [7:0] WALK_LAST   = 8'(WALK_TIME - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ped_pending_q, ped_pending_d;
  logic       ew_latched_q, ew_latched_d;
  logic [2:0] ns_light_q, ns_light_d;
  logic [2:0] ew_light_q, ew_light_d;
  logic       walk_q, walk_d;

  always_comb begin
    state_d       = state_q;
    ew_latched_d  = ew_latched_q;
    case (state_q)
      NS_G:    if (cnt_q == GREEN_LAST && (ew_req || ped_pending_q)) state_d = NS_Y;
      NS_Y:    if (cnt_q == YELLOW_LAST) state_d = AR_A;
      AR_A:    if (cnt_q == ALLRED_LAST) state_d = ew_latched_q ? EW_G : WALK;
      EW_G:    if (cnt_q == GREEN_LAST) state_d = EW_Y;
      EW_Y:    if (cnt_q == YELLOW_LAST) state_d = AR_B;
      AR_B:    if (cnt_q == ALLRED_LAST) state_d = ped_pending_q ? WALK : NS_G;
      WALK:    if (cnt_q == WALK_LAST) state_d = PED_CLR;
      PED_CLR: if (cnt_q == ALLRED_LAST) state_d = NS_G;
      default: state_d = AR_B;
    endcase

    if (state_q == NS_G && state_d == NS_Y) ew_latched_d = ew_req;

    // NS_G may rest indefinitely, so its counter parks at the expiry value.
    if (state_d != state_q) cnt_d = 8'd0;
    else if (state_q == NS_G && cnt_q == GREEN_LAST) cnt_d = cnt_q;
    else cnt_d = cnt_q + 8'd1;

    // A request coinciding with the WALK entry edge is served by that WALK.
    if (state_d == WALK && state_q != WALK) ped_pending_d = 1'b0;
    else if (ped_req) ped_pending_d = 1'b1;
    else ped_pending_d = ped_pending_q;

    ns_light_d = LIGHT_RED;
    ew_light_d = LIGHT_RED;
    walk_d     = 1'b0;
    case (state_d)
      NS_G:    ns_light_d = LIGHT_GREEN;
      NS_Y:    ns_light_d = LIGHT_YELLOW;
      EW_G:    ew_light_d = LIGHT_GREEN;
      EW_Y:    ew_light_d = LIGHT_YELLOW;
      WALK:    walk_d     = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= AR_B;
      cnt_q         <= 8'd0;
      ped_pending_q <= 1'b0;
      ew_latched_q  <= 1'b0;
      ns_light_q    <= LIGHT_RED;
      ew_light_q    <= LIGHT_RED;
      walk_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ped_pending_q <= ped_pending_d;
      ew_latched_q  <= ew_latched_d;
      ns_light_q    <= ns_light_d;
      ew_light_q    <= ew_light_d;
      walk_q        <= walk_d;
    end
  end

  assign ns_light = ns_light_q;
  assign ew_light = ew_light_q;
  assign walk     = walk_q;
  assign ped_wait = ped_pending_q;
  assign phase    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_intersection_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_intersection_controller: directed stimulus, phase-timeline model.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_intersection_controller;

  localparam int G = 10;
  localparam int Y = 5;
  localparam int A = 2;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       ew_req;
  logic       ped_req;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic       ped_wait;
  logic [2:0] phase;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  intersection_controller #(
    .GREEN_TIME(G), .YELLOW_TIME(Y), .ALLRED_TIME(A), .WALK_TIME(W)
  ) dut (
    .clk(clk), .reset(reset), .ew_req(ew_req), .ped_req(ped_req),
    .ns_light(ns_light), .ew_light(ew_light), .walk(walk),
    .ped_wait(ped_wait), .phase(phase)
  );

  always #5 clk = ~clk;

  // Model: current phase and how many cycles it has been showing.
  int m_ph;
  int m_age;
  bit m_pend;
  bit m_ewl;

  function automatic int dur(input int ph);
    case (ph)
      0, 3:    return G;
      1, 4:    return Y;
      6:       return W;
      default: return A;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ph <= 5; m_age <= 0; m_pend <= 1'b0; m_ewl <= 1'b0;
    end else begin
      automatic int nxt = m_ph;
      if (m_age + 1 >= dur(m_ph)) begin
        case (m_ph)
          0: if (ew_req || m_pend) nxt = 1;
          1: nxt = 2;
          2: nxt = m_ewl ? 3 : 6;
          3: nxt = 4;
          4: nxt = 5;
          5: nxt = m_pend ? 6 : 0;
          6: nxt = 7;
          default: nxt = 0;
        endcase
      end
      if (m_ph == 0 && nxt == 1) m_ewl <= ew_req;
      if (nxt == 6 && m_ph != 6) m_pend <= 1'b0;
      else if (ped_req) m_pend <= 1'b1;
      m_age <= (nxt == m_ph) ? m_age + 1 : 0;
      m_ph  <= nxt;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      automatic logic [2:0] e_ns = (m_ph == 0) ? 3'b001 : (m_ph == 1) ? 3'b010 : 3'b100;
      automatic logic [2:0] e_ew = (m_ph == 3) ? 3'b001 : (m_ph == 4) ? 3'b010 : 3'b100;
      automatic logic       e_wk = (m_ph == 6);
      automatic logic       safe;
      check("model {ns,ew,walk,wait,phase}",
            {21'd0, ns_light, ew_light, walk, ped_wait, phase},
            {21'd0, e_ns, e_ew, e_wk, m_pend, 3'(m_ph)});
      safe = (ns_light == 3'b100 || ew_light == 3'b100) &&
             (!walk || (ns_light == 3'b100 && ew_light == 3'b100));
      check("invariant", {31'd0, safe}, 32'd1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Assert reset off-edge, release it on a negedge (that negedge is N0).
  task automatic start(input logic ew);
    @(negedge clk);
    #2 reset = 1'b1;
    ew_req  = ew;
    ped_req = 1'b0;
    cyc(2);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ew_req = 1'b0; ped_req = 1'b0;
    cyc(3);
    chk_en = 1'b1;

    // Idle: rests in NS green.
    start(1'b0);
    check("t1 ph n0", phase, 5);
    check("t1 ns n0", ns_light, 3'b100);
    cyc(1); check("t1 ph n1", phase, 5);
    cyc(1); check("t1 ph n2", phase, 0); check("t1 ns n2", ns_light, 3'b001);
    cyc(200); check("t1 ns hold", ns_light, 3'b001); check("t1 walk", walk, 0);

    // Vehicle-only cycle, 34-cycle period.
    start(1'b1);
    check("t2 ph n0", phase, 5);
    cyc(1);  check("t2 ph n1", phase, 5);
    cyc(1);  check("t2 ph n2", phase, 0);
    cyc(9);  check("t2 ph n11", phase, 0);
    cyc(1);  check("t2 ph n12", phase, 1); check("t2 ns n12", ns_light, 3'b010);
    cyc(4);  check("t2 ph n16", phase, 1);
    cyc(1);  check("t2 ph n17", phase, 2);
    cyc(2);  check("t2 ph n19", phase, 3); check("t2 ew n19", ew_light, 3'b001);
    cyc(9);  check("t2 ph n28", phase, 3);
    cyc(1);  check("t2 ph n29", phase, 4); check("t2 ew n29", ew_light, 3'b010);
    cyc(5);  check("t2 ph n34", phase, 5);
    cyc(2);  check("t2 ph n36", phase, 0);
    cyc(34); check("t2 ph n70", phase, 0);
    cyc(17); check("t2 ph n87", phase, 3);

    // Pedestrian during EW green: served after AR_B.
    start(1'b1);
    cyc(19); check("t4 ph n19", phase, 3);
    cyc(2);  ped_req = 1'b1;
    cyc(1);  ped_req = 1'b0; check("t4 wait n22", ped_wait, 1);
    cyc(12); check("t4 ph n34", phase, 5);
    cyc(2);  check("t4 ph n36", phase, 6); check("t4 walk n36", walk, 1);
    check("t4 ew n36", ew_light, 3'b100); check("t4 wait n36", ped_wait, 0);
    cyc(7);  check("t4 ph n43", phase, 6);
    cyc(1);  check("t4 ph n44", phase, 7);
    cyc(2);  check("t4 ph n46", phase, 0);
    ew_req = 1'b0;

    // Pedestrian from NS green, then a second request during WALK.
    start(1'b0);
    cyc(6);  ped_req = 1'b1;
    cyc(1);  ped_req = 1'b0; check("t3 wait n7", ped_wait, 1); check("t3 ph n7", phase, 0);
    cyc(4);  check("t3 ph n11", phase, 0);
    cyc(1);  check("t3 ph n12", phase, 1);
    cyc(7);  check("t3 ph n19", phase, 6); check("t3 walk n19", walk, 1);
    check("t3 wait n19", ped_wait, 0);
    cyc(2);  ped_req = 1'b1; check("t5 wait n21", ped_wait, 0);
    cyc(1);  ped_req = 1'b0; check("t5 wait n22", ped_wait, 1);
    cyc(4);  check("t5 ph n26", phase, 6);
    cyc(1);  check("t5 ph n27", phase, 7);
    cyc(2);  check("t5 ph n29", phase, 0); check("t5 wait n29", ped_wait, 1);
    cyc(9);  check("t5 ph n38", phase, 0);
    cyc(1);  check("t5 ph n39", phase, 1);
    cyc(7);  check("t5 ph n46", phase, 6); check("t5 wait n46", ped_wait, 0);

    // Asynchronous reset in EW green cycle 4.
    start(1'b1);
    cyc(20); ped_req = 1'b1;
    cyc(1);  ped_req = 1'b0; check("t6 wait n21", ped_wait, 1);
    cyc(1);  check("t6 ph n22", phase, 3); check("t6 ew n22", ew_light, 3'b001);
    #2 reset = 1'b1;
    #1;
    check("t6 async ns", ns_light, 3'b100);
    check("t6 async ew", ew_light, 3'b100);
    check("t6 async walk", walk, 0);
    check("t6 async wait", ped_wait, 0);
    check("t6 async ph", phase, 5);
    cyc(2);  reset = 1'b0;
    check("t6 ph r0", phase, 5);
    cyc(1);  check("t6 ph r1", phase, 5);
    cyc(1);  check("t6 ph r2", phase, 0);
    cyc(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
